fetch_sequencer: RTL and testbench

- Sequences the program counter and instruction-memory fetch for the RV32 core.
- Owns the PC register and issues one outstanding fetch at a time over a valid/ready request and a valid-only response.
- Buffers one instruction toward decode and applies branch/jal/jalr redirects from execute.
- Squashes any fetch that is stale at the time of a redirect.

---
 rtl/fetch_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : RV32 instruction-fetch sequencer. Owns the program counter,
//               issues at most one outstanding instruction-memory fetch over a
//               valid/ready request channel with a valid-only response, and
//               buffers one instruction toward decode. Branch, jal and jalr
//               redirects from execute retarget the PC; any fetch that was
//               already in flight when a redirect arrives is squashed.
//
// Ports       : clk, rst              clock, synchronous active-high reset
//               redirect_kind         00/10 none, 01 branch/jal, 11 jalr
//               redirect_pc/rs1/imm   operands of the redirect target
//               imem_req_valid/ready  fetch request handshake
//               imem_req_addr         fetch address (held while stalled)
//               imem_rsp_valid/data   one response per accepted request
//               if_valid/ready        instruction handshake toward decode
//               if_instr, if_pc       buffered instruction and its address
//               perf_fetched          (FETCH_PERF_EN) delivered instructions
//               perf_squashed         (FETCH_PERF_EN) discarded fetches
//
// Options     : define FETCH_PERF_EN to add the two 32-bit wrapping
//               performance counters; without it the ports do not exist.
//
// Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          redirect_kind,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [PC_WIDTH-1:0] redirect_rs1,
    input  logic [PC_WIDTH-1:0] redirect_imm,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [PC_WIDTH-1:0] imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [31:0]         imem_rsp_data,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [31:0]         if_instr,
    output logic [PC_WIDTH-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_squashed
`endif
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE = 3'd0;  // one bubble after reset
    localparam logic [2:0] c_ST_REQ  = 3'd1;  // request presented to memory
    localparam logic [2:0] c_ST_WAIT = 3'd2;  // request accepted, awaiting data
    localparam logic [2:0] c_ST_HOLD = 3'd3;  // instruction buffered for decode
    localparam logic [2:0] c_ST_DROP = 3'd4;  // awaiting a stale response

    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] c_LSB_CLR = ~(PC_WIDTH'(1));

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [PC_WIDTH-1:0] r_pc;          // address of the next fetch
    logic                r_redir_pend;  // a redirect is waiting for a drain
    logic [PC_WIDTH-1:0] r_redir_tgt;   // latest redirect target seen
    logic                r_req_valid;
    logic                r_buf_valid;
    logic [31:0]         r_if_instr;
    logic [PC_WIDTH-1:0] r_if_pc;

    // ------------------------------------------------------------------------
    // Redirect decode and target arithmetic (modulo 2^PC_WIDTH)
    // ------------------------------------------------------------------------
    logic                w_redir;
    logic [PC_WIDTH-1:0] w_branch_tgt;
    logic [PC_WIDTH-1:0] w_jalr_sum;
    logic [PC_WIDTH-1:0] w_jalr_tgt;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_pc_seq;

    assign w_redir      = redirect_kind[0];
    assign w_branch_tgt = redirect_pc + redirect_imm;
    assign w_jalr_sum   = redirect_rs1 + redirect_imm;
    assign w_jalr_tgt   = w_jalr_sum & c_LSB_CLR;
    assign w_target     = redirect_kind[1] ? w_jalr_tgt : w_branch_tgt;
    assign w_pc_seq     = r_pc + c_PC_STEP;

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_pc;
    // The buffered instruction belongs to the pre-redirect path, so it must be
    // hidden in the same cycle the redirect shows up.
    assign if_valid       = r_buf_valid & ~w_redir;
    assign if_instr       = r_if_instr;
    assign if_pc          = r_if_pc;

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= '0;
            r_req_valid  <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_redir) begin
                        r_pc <= w_target;
                    end
                    r_state     <= c_ST_REQ;
                    r_req_valid <= 1'b1;
                end

                c_ST_REQ: begin
                    // The address never changes while the request is offered;
                    // a redirect here is remembered and applied after drain.
                    if (imem_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (r_redir_pend || w_redir) begin
                            r_state      <= c_ST_DROP;
                            r_redir_pend <= 1'b1;
                            if (w_redir) begin
                                r_redir_tgt <= w_target;
                            end
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end else if (w_redir) begin
                        r_redir_tgt  <= w_target;
                        r_redir_pend <= 1'b1;
                    end
                end

                c_ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (w_redir) begin
                            // Response arrives together with the redirect:
                            // nothing left in flight, refetch immediately.
                            r_pc        <= w_target;
                            r_state     <= c_ST_REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_if_instr  <= imem_rsp_data;
                            r_if_pc     <= r_pc;
                            r_pc        <= w_pc_seq;
                            r_buf_valid <= 1'b1;
                            r_state     <= c_ST_HOLD;
                        end
                    end else if (w_redir) begin
                        r_redir_tgt  <= w_target;
                        r_redir_pend <= 1'b1;
                        r_state      <= c_ST_DROP;
                    end
                end

                c_ST_HOLD: begin
                    // Redirect outranks the decode handshake.
                    if (w_redir) begin
                        r_pc        <= w_target;
                        r_buf_valid <= 1'b0;
                        r_state     <= c_ST_REQ;
                        r_req_valid <= 1'b1;
                    end else if (if_ready) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= c_ST_REQ;
                        r_req_valid <= 1'b1;
                    end
                end

                c_ST_DROP: begin
                    if (imem_rsp_valid) begin
                        r_pc         <= w_redir ? w_target : r_redir_tgt;
                        r_redir_pend <= 1'b0;
                        r_state      <= c_ST_REQ;
                        r_req_valid  <= 1'b1;
                    end else if (w_redir) begin
                        r_redir_tgt <= w_target;
                    end
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_req_valid <= 1'b0;
                    r_buf_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Performance counters (free-running, wrapping)
    // ------------------------------------------------------------------------
    logic        w_fire;
    logic        w_squash;
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_squashed;

    assign w_fire   = if_valid & if_ready;
    // A response is discarded when it lands in DROP or collides with a
    // redirect in WAIT; a held instruction is discarded by a redirect.
    assign w_squash = (imem_rsp_valid & (r_state == c_ST_DROP))
                    | (imem_rsp_valid & w_redir & (r_state == c_ST_WAIT))
                    | (w_redir & (r_state == c_ST_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched  <= '0;
            r_perf_squashed <= '0;
        end else begin
            if (w_fire) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_squash) begin
                r_perf_squashed <= r_perf_squashed + 32'd1;
            end
        end
    end

    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A transaction-level
//               model tracks the architectural next-fetch address, the single
//               outstanding fetch and the decode buffer, and is compared with
//               the DUT every cycle; directed scenarios pin literal values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  redirect_kind;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_rs1;
    logic [31:0] redirect_imm;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    fetch_sequencer #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_kind  (redirect_kind),
        .redirect_pc    (redirect_pc),
        .redirect_rs1   (redirect_rs1),
        .redirect_imm   (redirect_imm),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [31:0] target_of(input logic [1:0] k, input logic [31:0] pc,
                                              input logic [31:0] rs1, input logic [31:0] imm);
        logic [31:0] s;
        if (k[1]) begin
            s = rs1 + imm;
            s[0] = 1'b0;
        end else begin
            s = pc + imm;
        end
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Memory: accepts a request, answers after rsp_lat cycles (>= 1)
    // ------------------------------------------------------------------------
    int          rsp_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mem_cnt = 0;
            end else if (imem_req_valid && imem_req_ready) begin
                mem_cnt  = rsp_lat;
                mem_addr = imem_req_addr;
            end
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Reference model: evaluated at negedge, where every signal already holds
    // the value the next rising edge will sample.
    // ------------------------------------------------------------------------
    bit          m_ok = 1'b0;
    bit          m_out, m_out_stale, m_req_stale, m_buf, m_stall_prev;
    logic [31:0] m_out_addr, m_buf_pc, m_buf_instr, m_exp_pc, m_stall_addr;
    logic [31:0] m_fetched, m_squashed;
    logic        m_redir;
    logic [31:0] m_tgt;

    always @(negedge clk) begin
        if (m_ok) begin
            check("if_valid", if_valid, m_buf && !redirect_kind[0]);
            if (m_buf && if_valid) begin
                check("if_pc", if_pc, m_buf_pc);
                check("if_instr", if_instr, m_buf_instr);
            end
            if (imem_req_valid) check("one_outstanding", m_out, 0);
            if (m_stall_prev) begin
                check("req_hold_valid", imem_req_valid, 1);
                check("req_hold_addr", imem_req_addr, m_stall_addr);
            end
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_squashed", perf_squashed, m_squashed);
`endif
        end
        if (rst) begin
            m_ok = 1'b1; m_out = 0; m_out_stale = 0; m_req_stale = 0; m_buf = 0;
            m_stall_prev = 0; m_exp_pc = 32'h0; m_fetched = 0; m_squashed = 0;
        end else if (m_ok) begin
            m_redir = redirect_kind[0];
            m_tgt   = target_of(redirect_kind, redirect_pc, redirect_rs1, redirect_imm);
            if (m_buf) begin
                if (m_redir) begin
                    m_buf = 0; m_squashed++;
                end else if (if_ready) begin
                    m_buf = 0; m_fetched++;
                end
            end
            if (imem_rsp_valid && m_out) begin
                m_out = 0;
                if (m_out_stale || m_redir) begin
                    m_squashed++;
                end else begin
                    m_buf = 1; m_buf_pc = m_out_addr; m_buf_instr = mem_word(m_out_addr);
                    m_exp_pc = m_out_addr + 32'd4;
                end
            end
            m_stall_prev = 0;
            if (imem_req_valid && imem_req_ready) begin
                if (!(m_req_stale || m_redir)) check("req_addr", imem_req_addr, m_exp_pc);
                m_out = 1; m_out_addr = imem_req_addr;
                m_out_stale = m_req_stale || m_redir; m_req_stale = 0;
            end else if (imem_req_valid) begin
                m_stall_prev = 1; m_stall_addr = imem_req_addr;
                if (m_redir) m_req_stale = 1;
            end
            if (m_redir) begin
                m_exp_pc = m_tgt;
                if (m_out) m_out_stale = 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_if(input int budget);
        int n = 0;
        while (!if_valid && n < budget) begin
            step();
            n++;
        end
        check("wait_if_valid", if_valid, 1);
    endtask

    task automatic wait_req_no_if(input int budget);
        int n = 0;
        while (!imem_req_valid && n < budget) begin
            check("no_if_valid_while_draining", if_valid, 0);
            step();
            n++;
        end
        check("wait_req_valid", imem_req_valid, 1);
    endtask

    int t0;

    initial begin
        rst = 1'b1; redirect_kind = 2'b00; redirect_pc = '0; redirect_rs1 = '0;
        redirect_imm = '0; imem_req_ready = 1'b1; if_ready = 1'b1;
        step(); step();
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 32'h0);
        rst = 1'b0;

        // Boot: bubble, then request 0, deliveries every 3 cycles
        step();
        check("boot_req_valid", imem_req_valid, 1);
        check("boot_req_addr", imem_req_addr, 32'h0);
        wait_if(10);
        check("boot_pc0", if_pc, 32'h0);
        check("boot_instr0", if_instr, 32'hA5A50013);
        t0 = cyc;
        step(); wait_if(10);
        check("boot_pc4", if_pc, 32'h4);
        check("boot_instr4", if_instr, 32'hA5A50017);
        check("boot_spacing4", cyc - t0, 3);
        t0 = cyc;
        step(); if_ready = 1'b0; wait_if(10);
        check("boot_pc8", if_pc, 32'h8);
        check("boot_spacing8", cyc - t0, 3);

        // Decode stall for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_if_valid", if_valid, 1);
            check("stall_if_pc", if_pc, 32'h8);
            check("stall_if_instr", if_instr, 32'hA5A5001B);
            check("stall_no_req", imem_req_valid, 0);
        end
        if_ready = 1'b1; step();
        check("resume_req_valid", imem_req_valid, 1);
        check("resume_req_addr", imem_req_addr, 32'hC);

        // Branch while the fetch of 0x14 is outstanding (3-cycle memory)
        rsp_lat = 3;
        wait_if(20); check("lat3_pcC", if_pc, 32'hC);
        step(); wait_if(20); check("lat3_pc10", if_pc, 32'h10);
        step(); check("req14_addr", imem_req_addr, 32'h14);
        step(); check("req14_accepted", imem_req_valid, 0);
        redirect_kind = 2'b01; redirect_pc = 32'h10; redirect_imm = 32'h20;
        step(); redirect_kind = 2'b00;
        wait_req_no_if(20);
        check("branch_req_addr", imem_req_addr, 32'h30);
`ifdef FETCH_PERF_EN
        check("perf_squashed_after_branch", perf_squashed, 32'd1);
        check("perf_fetched_after_branch", perf_fetched, 32'd5);
`endif

        // Jalr in HOLD with if_ready high: masked, target bit 0 cleared
        rsp_lat = 1;
        wait_if(10); check("pc30", if_pc, 32'h30);
        redirect_kind = 2'b11; redirect_rs1 = 32'h101; redirect_imm = 32'h4;
        #1; check("jalr_mask", if_valid, 0);
        step(); redirect_kind = 2'b00;
        check("jalr_req_valid", imem_req_valid, 1);
        check("jalr_req_addr", imem_req_addr, 32'h104);

        // Back-to-back redirects while draining: latest wins
        rsp_lat = 3;
        step();
        redirect_kind = 2'b01; redirect_pc = 32'h0; redirect_imm = 32'h40;
        step(); redirect_imm = 32'h80;
        step(); redirect_kind = 2'b00;
        wait_req_no_if(20);
        check("latest_wins_addr", imem_req_addr, 32'h80);
        rsp_lat = 1;
        wait_if(10); check("pc80", if_pc, 32'h80);
        check("instr80", if_instr, 32'hA5A50093);

        // PC wrap
        redirect_kind = 2'b01; redirect_pc = 32'hFFFFFFF0; redirect_imm = 32'hC;
        step(); redirect_kind = 2'b00;
        check("wrap_req_addr", imem_req_addr, 32'hFFFFFFFC);
        wait_if(10); check("wrap_pc", if_pc, 32'hFFFFFFFC);
        step(); check("wrap_next_addr", imem_req_addr, 32'h0);
        wait_if(10); check("wrap_pc0", if_pc, 32'h0);
        step(); check("pre_rst_addr", imem_req_addr, 32'h4);

        // Reset while a request is stalled
        imem_req_ready = 1'b0;
        step(); step();
        check("stalled_addr", imem_req_addr, 32'h4);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_req_valid", imem_req_valid, 0);
        check("midrst_req_addr", imem_req_addr, 32'h0);
        check("midrst_if_valid", if_valid, 0);
`ifdef FETCH_PERF_EN
        check("midrst_perf_fetched", perf_fetched, 32'd0);
        check("midrst_perf_squashed", perf_squashed, 32'd0);
`endif
        imem_req_ready = 1'b1;
        wait_if(20); check("reboot_pc", if_pc, 32'h0);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
